// File: rtl/led_blink_arbiter.sv
// led_blink_arbiter: shares one board LED between N_REQ requesters.
// A round-robin arbiter grants one requester at a time. The granted
// requester's 8-bit pattern is captured at grant and played LSB first.
// Each bit lasts one prescaler period (TICK_DIV clk cycles). The first
// bit starts on a tick boundary, so every bit has the same length. A
// requester dropping its request aborts its own slot.

module led_blink_arbiter #(
    parameter int N_REQ    = 4,
    parameter int TICK_DIV = 12_500_000,
    parameter int TICK_W   = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   pattern,
    output logic [N_REQ-1:0]     grant,
    output logic                 busy,
    output logic                 led
);

    localparam int                 IDX_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0]   RR_RESET  = IDX_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_PLAY  = 2'd2
    } state_e;

    // Registered state
    state_e             state_q;
    logic [TICK_W-1:0]  presc_q;
    logic [TICK_W-1:0]  presc_d;
    logic [2:0]         bit_idx_q;
    logic [7:0]         pattern_q;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic [IDX_W-1:0]   winner_q;
    logic [N_REQ-1:0]   grant_q;
    logic               busy_q;
    logic               led_q;

    // Combinational helpers
    logic               tick_s;
    logic               found_s;
    logic [IDX_W-1:0]   pick_s;
    logic [IDX_W-1:0]   cand_s;
    logic               owner_req_s;
    logic [7:0]         pat_s [N_REQ];

    assign grant = grant_q;
    assign busy  = busy_q;
    assign led   = led_q;

    // Split the packed pattern bus into one byte per requester
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            pat_s[i] = pattern[8*i +: 8];
        end
    end

    // Prescaler next value and the one-cycle tick at its terminal count
    always_comb begin
        tick_s = (presc_q == TICK_LAST);
        if (tick_s) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + TICK_W'(1);
        end
    end

    // Free-running prescaler; arbitration never touches it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    // Round-robin scan: first requester at or after rr_ptr+1, wrapping
    always_comb begin
        found_s = 1'b0;
        pick_s  = '0;
        cand_s  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand_s = IDX_W'((int'(rr_ptr_q) + k) % N_REQ);
            if (!found_s && req[cand_s]) begin
                found_s = 1'b1;
                pick_s  = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Current owner still requesting; a low level means abort
    always_comb begin
        owner_req_s = req[winner_q];
    end

    // Arbitration and playback FSM with registered grant/busy/led
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bit_idx_q <= 3'd0;
            pattern_q <= 8'd0;
            rr_ptr_q  <= RR_RESET;
            winner_q  <= '0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            led_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    led_q     <= 1'b0;
                    bit_idx_q <= 3'd0;
                    if (found_s) begin
                        state_q   <= ST_ALIGN;
                        winner_q  <= pick_s;
                        pattern_q <= pat_s[pick_s];
                        grant_q   <= N_REQ'(1) << pick_s;
                        busy_q    <= 1'b1;
                    end else begin
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                    end
                end

                ST_ALIGN: begin
                    // Abort outranks the tick in the same cycle
                    if (!owner_req_s) begin
                        state_q  <= ST_IDLE;
                        grant_q  <= '0;
                        busy_q   <= 1'b0;
                        led_q    <= 1'b0;
                        rr_ptr_q <= winner_q;
                    end else if (tick_s) begin
                        state_q   <= ST_PLAY;
                        bit_idx_q <= 3'd0;
                        led_q     <= pattern_q[0];
                    end else begin
                        led_q <= 1'b0;
                    end
                end

                ST_PLAY: begin
                    if (!owner_req_s) begin
                        state_q  <= ST_IDLE;
                        grant_q  <= '0;
                        busy_q   <= 1'b0;
                        led_q    <= 1'b0;
                        rr_ptr_q <= winner_q;
                    end else if (tick_s) begin
                        if (bit_idx_q == 3'd7) begin
                            // Slot complete: release the LED and rotate priority
                            state_q  <= ST_IDLE;
                            grant_q  <= '0;
                            busy_q   <= 1'b0;
                            led_q    <= 1'b0;
                            rr_ptr_q <= winner_q;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            led_q     <= pattern_q[bit_idx_q + 3'd1];
                        end
                    end else begin
                        led_q <= pattern_q[bit_idx_q];
                    end
                end

                default: begin
                    state_q   <= ST_IDLE;
                    bit_idx_q <= 3'd0;
                    grant_q   <= '0;
                    busy_q    <= 1'b0;
                    led_q     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_blink_arbiter.sv
// Scoreboard bench for led_blink_arbiter. After each clock edge the
// reference model pushes the expected outputs into a queue. A separate
// monitor on the falling edge pops and compares them. The model tracks
// the owner, its captured pattern and the number of ticks seen since
// the grant. The LED shows bit (ticks-1) for ticks 1..8. The slot ends
// when the ninth tick arrives.

module tb_led_blink_arbiter;

    localparam int N  = 4;
    localparam int TD = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [N-1:0]       req = '0;
    logic [8*N-1:0]     pattern = '0;
    logic [N-1:0]       grant;
    logic               busy;
    logic               led;

    led_blink_arbiter #(.N_REQ(N), .TICK_DIV(TD), .TICK_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .pattern (pattern),
        .grant   (grant),
        .busy    (busy),
        .led     (led)
    );

    always #5 clk = ~clk;

    typedef logic [N+1:0] exp_t;   // {grant, busy, led}
    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;

    // reference model state
    int         m_owner;
    int         m_rr;
    int         m_ticks;
    int         m_edge;
    logic [7:0] m_cap;

    task automatic model_reset();
        m_owner = -1;
        m_rr    = N - 1;
        m_ticks = 0;
        m_edge  = 0;
        m_cap   = 8'd0;
    endtask

    // Evaluate one rising edge using the inputs the DUT sampled
    task automatic model_edge();
        logic       tick;
        logic [N-1:0] g;
        logic       l;
        int         c;
        m_edge = m_edge + 1;
        tick   = ((m_edge % TD) == 0);
        if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                c = (m_rr + k) % N;
                if (m_owner < 0 && req[c]) begin
                    m_owner = c;
                    m_cap   = pattern[c*8 +: 8];
                    m_ticks = 0;
                end
            end
        end else if (!req[m_owner]) begin
            m_rr    = m_owner;
            m_owner = -1;
        end else if (tick) begin
            m_ticks = m_ticks + 1;
            if (m_ticks == 9) begin
                m_rr    = m_owner;
                m_owner = -1;
            end
        end
        g = '0;
        l = 1'b0;
        if (m_owner >= 0) begin
            g[m_owner] = 1'b1;
            if (m_ticks >= 1) l = m_cap[m_ticks-1];
        end
        exp_q.push_back({g, (m_owner >= 0), l});
    endtask

    // Monitor: compare DUT outputs against the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total = total + 1;
            if ({grant, busy, led} !== e) begin
                bad = bad + 1;
                $display("FAIL outputs t=%0t got grant=%b busy=%b led=%b want grant=%b busy=%b led=%b",
                         $time, grant, busy, led, e[N+1:2], e[1], e[0]);
            end
        end
    end

    // Drive one cycle of inputs, then run the model on the edge
    task automatic cyc(input logic [N-1:0] r, input logic [8*N-1:0] p);
        req     = r;
        pattern = p;
        @(posedge clk);
        model_edge();
        #2;
    endtask

    task automatic check_zero(input string name, input logic v);
        total = total + 1;
        if (v !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL %s got=%b want=0", name, v);
        end
    endtask

    logic [N-1:0]   r_cur;
    logic [8*N-1:0] p_cur;

    task automatic random_phase(input int cycles);
        for (int n = 0; n < cycles; n++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(39) == 0) r_cur[i] = ~r_cur[i];
                if ($urandom_range(19) == 0) p_cur[i*8 +: 8] = 8'($urandom());
            end
            cyc(r_cur, p_cur);
        end
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        check_zero("reset_grant", |grant);
        check_zero("reset_busy", busy);
        check_zero("reset_led", led);
        rst_n = 1'b1;

        // idle with no requests
        repeat (20) cyc(4'b0000, 32'h0);

        // single slot, pattern A5 on requester 0
        repeat (50) cyc(4'b0001, 32'h000000A5);
        repeat (4)  cyc(4'b0000, 32'h0);

        // all requesters, distinct patterns: round-robin rotation
        repeat (200) cyc(4'b1111, 32'h3C960FA5);
        repeat (3)   cyc(4'b0000, 32'h0);

        // requester 2 then requester 3; drop 2 mid-play to abort
        repeat (20) cyc(4'b0100, 32'h00C30000);
        repeat (10) cyc(4'b1000, 32'h81C30000);
        repeat (50) cyc(4'b1001, 32'h81C300FF);
        repeat (3)  cyc(4'b0000, 32'h0);

        // pattern change after grant is ignored; late request waits
        repeat (8)  cyc(4'b0001, 32'h000000FF);
        repeat (10) cyc(4'b0001, 32'h00000000);
        repeat (40) cyc(4'b0011, 32'h00005A00);
        repeat (3)  cyc(4'b0000, 32'h0);

        // randomized traffic
        r_cur = '0;
        p_cur = 32'($urandom());
        random_phase(700);

        // asynchronous reset mid-cycle: outputs clear before the next edge
        r_cur = 4'b1111;
        repeat (12) cyc(r_cur, p_cur);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_zero("async_grant", |grant);
        check_zero("async_busy", busy);
        check_zero("async_led", led);
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;

        random_phase(800);

        // expectations must all have been consumed
        @(negedge clk);
        #1;
        total = total + 1;
        if (exp_q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL drain got=%0d want=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_blink_arbiter.md
Name: led_blink_arbiter

Overview:
- Shares the single board LED between N_REQ requesters, such as status sources in a demo top.
- Each requester asks for the LED with an 8-bit blink pattern. A round-robin arbiter grants one requester at a time.
- The granted pattern is played one bit per prescaled tick for one 8-tick slot.
- Sits between requester logic and the LED pin. Replaces the free-running counter LED drive.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TICK_DIV, 12_500_000, clk cycles per pattern bit (>=2). At 100 MHz this is 125 ms.
- TICK_W, 24, width of the prescaler counter. Must hold TICK_DIV-1.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset; release is synchronous to clk at the board level.
- req  in  N_REQ  per-requester level request; bit i belongs to requester i.
- pattern  in  8*N_REQ  requester i pattern on bits [8i+7:8i]; bit 0 is played first.
- grant  out  N_REQ  one-hot (or zero) ownership indication, registered.
- busy  out  1  high when state != IDLE, registered.
- led  out  1  registered LED drive.

Behaviour:
- Reset (rst_n low, asynchronous), all registers cleared:
  - outputs: grant=0, busy=0, led=0
  - internal: state=IDLE, prescaler=0, bit_idx=0, pattern_reg=0
  - rr_ptr=N_REQ-1, so requester 0 has the highest priority after reset.
- Prescaler:
  - Free-running 0..TICK_DIV-1, wraps to 0.
  - tick is an internal 1-cycle pulse when prescaler==TICK_DIV-1.
  - The prescaler is never reset by arbitration.
- State machine has three states: IDLE, ALIGN, PLAY.
- IDLE:
  - If any req bit is high, pick the first set bit scanning upward from rr_ptr+1 (mod N_REQ).
  - Next cycle: grant = onehot(winner), busy=1, pattern_reg = that requester's pattern sampled in the same cycle, state=ALIGN.
  - Latency is req high at edge t -> grant high after edge t+1 (one cycle).
  - If no req is high, hold everything; led=0.
- ALIGN:
  - Wait for tick. On tick: state=PLAY, bit_idx=0, led=pattern_reg[0].
  - This guarantees every played bit lasts exactly TICK_DIV cycles.
- PLAY:
  - led = pattern_reg[bit_idx].
  - On tick with bit_idx<7: bit_idx+1, led takes the new bit.
  - On tick with bit_idx==7 (slot end): state=IDLE, grant=0, busy=0, led=0, rr_ptr=winner index.
- Abort:
  - In ALIGN or PLAY, if req[winner] is low at a clock edge, next cycle: state=IDLE, grant=0, busy=0, led=0, rr_ptr=winner.
  - Abort has priority over tick in the same cycle.
- Pattern changes after grant are ignored; only the captured pattern_reg is played.
- Requests from non-owners during a slot are not serviced until IDLE. No preemption.
- After any slot end or abort, at least one IDLE cycle elapses before the next grant. grant is never non-zero in IDLE.
- Fairness: a requester holding req continuously is granted within N_REQ-1 slots of any other grant.
- Simultaneous requests in IDLE: round-robin from rr_ptr+1 only. No fixed priority beyond the reset value of rr_ptr.
- Width rules:
  - winner index is clog2(N_REQ) bits, min 1.
  - bit_idx is 3 bits.
  - prescaler compare is done at TICK_W bits.
- Invariants (verification checks): grant is zero or one-hot; busy == |grant; led==0 whenever state != PLAY.

Test Plan:
1. Reset and idle: TICK_DIV=4. Hold rst_n low 3 cycles, release, no req for 20 cycles -> grant=0, busy=0, led=0 throughout. Assert rst_n low asynchronously mid-cycle -> outputs 0 before the next edge.
2. Single slot: TICK_DIV=4, req=4'b0001, pattern0=8'hA5 -> grant=0001 one cycle later. After the next tick, led plays 1,0,1,0,0,1,0,1, each exactly 4 cycles. Then grant=0, busy=0, led=0, with at least one IDLE cycle before a re-grant.
3. Round-robin: all four req held high, distinct patterns -> grants in order 0001,0010,0100,1000,0001. Each slot is 8 ticks plus its ALIGN wait.
4. Abort: requester 2 granted and in PLAY at bit_idx=3; drop req[2] -> next cycle grant=0, led=0, busy=0. With req[3] high, requester 3 is granted next, not requester 0.
5. Abort and tick in the same cycle: drop req on the tick cycle at bit_idx==7 -> behaves as an abort (rr_ptr=winner). No extra led bit appears.
6. Pattern change and late request: change pattern0 from 8'hFF to 8'h00 mid-slot -> led stays 1 for all 8 bits. req[1] raised mid-slot of requester 0 -> granted only after the slot ends.
